vreg_commit_queue: RTL and testbench

VREG_COMMIT_QUEUE -- requirements
Module: vreg_commit_queue

---
 rtl/vreg_commit_queue.sv | 163 ++++++++++++++++
 tb/tb_vreg_commit_queue.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vreg_commit_queue.sv
// Vector register commit queue: multi-port write-back capture into a FIFO,
// drained one register beat per handshake with sticky drop accounting.
module vreg_commit_queue #(
  parameter int unsigned VLEN   = 1024,
  parameter int unsigned NPORT  = 2,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned MAXGRP = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NPORT-1:0]              in_valid,
  input  logic [NPORT-1:0]              in_is_store,
  input  logic [NPORT-1:0]              in_wr_rf,
  input  logic [8*NPORT-1:0]            in_rf_addr,
  input  logic [8*NPORT-1:0]            in_group_size,
  input  logic [NPORT*MAXGRP*VLEN-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_is_store,
  output logic                          out_wr_rf,
  output logic [7:0]                    out_rf_addr,
  output logic [7:0]                    out_beat,
  output logic                          out_last,
  output logic [VLEN-1:0]               out_data,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          overflow,
  output logic [15:0]                   drop_cnt,
  input  logic                          clr_status
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = MAXGRP * VLEN;

  function automatic logic [7:0] eff_size(input logic [7:0] gs);
    if (gs == 8'd0)             return 8'd1;
    else if (32'(gs) > MAXGRP)  return 8'(MAXGRP);
    else                        return gs;
  endfunction

  logic [EW-1:0] data_mem  [DEPTH];
  logic [7:0]    addr_mem  [DEPTH];
  logic [7:0]    grp_mem   [DEPTH];
  logic          store_mem [DEPTH];
  logic          wr_mem    [DEPTH];

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]    beat_q, beat_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;

  logic [NPORT-1:0] vld;
  logic [NPORT-1:0] acc;
  logic [AW-1:0]    slot [NPORT];
  logic [CW-1:0]    space;
  logic [CW-1:0]    n_push;
  logic [15:0]      n_drop;
  logic [16:0]      drop_sum;
  logic             handshake;
  logic             pop;
  logic [7:0]       head_grp;
  logic [EW-1:0]    head_data;

  assign vld = in_valid & ~{NPORT{reset}};

  // Space is judged from the registered count, so a pop this cycle never
  // makes room for a push this cycle; ports claim slots in index order.
  always_comb begin
    space  = CW'(DEPTH) - count_q;
    n_push = '0;
    n_drop = '0;
    acc    = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      slot[p] = '0;
      if (vld[p]) begin
        if (n_push < space) begin
          acc[p]  = 1'b1;
          slot[p] = wr_ptr_q + n_push[AW-1:0];
          n_push  = n_push + CW'(1);
        end else begin
          n_drop = n_drop + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (acc[p]) begin
        data_mem[slot[p]]  <= in_data[p*EW +: EW];
        addr_mem[slot[p]]  <= in_rf_addr[p*8 +: 8];
        grp_mem[slot[p]]   <= eff_size(in_group_size[p*8 +: 8]);
        store_mem[slot[p]] <= in_is_store[p];
        wr_mem[slot[p]]    <= in_wr_rf[p];
      end
    end
  end

  assign head_grp  = grp_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];

  always_comb begin
    out_valid    = (count_q != '0);
    out_is_store = store_mem[rd_ptr_q];
    out_wr_rf    = wr_mem[rd_ptr_q];
    out_rf_addr  = addr_mem[rd_ptr_q] + beat_q;
    out_beat     = beat_q;
    out_last     = (beat_q == head_grp - 8'd1);
    out_data     = head_data[32'(beat_q)*VLEN +: VLEN];
    handshake    = out_valid && out_ready;
    pop          = handshake && out_last;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + n_push[AW-1:0];
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + n_push - CW'(pop);
    beat_d   = beat_q;
    if (handshake) beat_d = out_last ? 8'd0 : beat_q + 8'd1;
  end

  // A drop in the same cycle as a clear wins: the counter restarts at this
  // cycle's drop count instead of zero.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    drop_sum   = {1'b0, drop_cnt_q} + {1'b0, n_drop};
    if (n_drop != '0) begin
      overflow_d = 1'b1;
      if (clr_status)        drop_cnt_d = n_drop;
      else if (drop_sum[16]) drop_cnt_d = '1;
      else                   drop_cnt_d = drop_sum[15:0];
    end else if (clr_status) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_q     <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_q     <= beat_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_vreg_commit_queue.sv
// Scoreboard bench for vreg_commit_queue: directed captures queue expected
// beats, a negedge monitor pops and compares every output handshake.
module tb_vreg_commit_queue;

  localparam int unsigned VLEN   = 32;
  localparam int unsigned NPORT  = 2;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned MAXGRP = 8;

  logic                         clk = 1'b0;
  logic                         reset;
  logic [NPORT-1:0]             in_valid, in_is_store, in_wr_rf;
  logic [8*NPORT-1:0]           in_rf_addr, in_group_size;
  logic [NPORT*MAXGRP*VLEN-1:0] in_data;
  logic                         out_valid, out_ready, out_is_store, out_wr_rf, out_last;
  logic [7:0]                   out_rf_addr, out_beat;
  logic [VLEN-1:0]              out_data;
  logic [3:0]                   count;
  logic                         overflow, clr_status;
  logic [15:0]                  drop_cnt;

  vreg_commit_queue #(.VLEN(VLEN), .NPORT(NPORT), .DEPTH(DEPTH), .MAXGRP(MAXGRP)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_is_store(in_is_store), .in_wr_rf(in_wr_rf),
    .in_rf_addr(in_rf_addr), .in_group_size(in_group_size), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_is_store(out_is_store),
    .out_wr_rf(out_wr_rf), .out_rf_addr(out_rf_addr), .out_beat(out_beat),
    .out_last(out_last), .out_data(out_data),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt), .clr_status(clr_status)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        st;
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  beat;
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t sb[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic [31:0] slice_val(input int tag, input int g);
    return {8'hA5, 8'(tag), 8'h3C, 8'(g)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one capture port; queue up to exp_beats of its expected beats.
  task automatic set_port(input int p, input logic st, input logic wr, input logic [7:0] addr,
                          input logic [7:0] gs, input int tag, input int exp_beats);
    int geff;
    beat_t b;
    in_valid[p]             = 1'b1;
    in_is_store[p]          = st;
    in_wr_rf[p]             = wr;
    in_rf_addr[p*8 +: 8]    = addr;
    in_group_size[p*8 +: 8] = gs;
    for (int g = 0; g < int'(MAXGRP); g++)
      in_data[(p*int'(MAXGRP)+g)*int'(VLEN) +: VLEN] = slice_val(tag, g);
    geff = (gs == 8'd0) ? 1 : (int'(gs) > int'(MAXGRP)) ? int'(MAXGRP) : int'(gs);
    for (int i = 0; i < geff && i < exp_beats; i++) begin
      b.st = st; b.wr = wr; b.addr = addr + 8'(i); b.beat = 8'(i);
      b.last = (i == geff - 1); b.data = slice_val(tag, i);
      sb.push_back(b);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    in_valid   = '0;
    clr_status = 1'b0;
  endtask

  task automatic drain(input string name, input int max_cycles);
    out_ready = 1'b1;
    for (int i = 0; i < max_cycles; i++) begin
      if (sb.size() == 0 && count == 4'd0) break;
      @(posedge clk); #1;
    end
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({name, "_count0"}, 32'(count), 32'd0);
  endtask

  // Monitor: every handshake is compared against the scoreboard head, and a
  // stalled beat must look identical on the following cycle.
  beat_t cur, prev, e;
  logic  prev_stall = 1'b0;
  always_comb cur = '{out_is_store, out_wr_rf, out_rf_addr, out_beat, out_last, out_data};

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || cur !== prev) begin
          errors++;
          $display("FAIL stall_stable: got v=%0b %0h expected v=1 %0h", out_valid, cur, prev);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %0h expected none", cur);
        end else begin
          e = sb.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL beat: got st=%0b wr=%0b addr=%0d beat=%0d last=%0b data=%0h expected st=%0b wr=%0b addr=%0d beat=%0d last=%0b data=%0h",
                     cur.st, cur.wr, cur.addr, cur.beat, cur.last, cur.data,
                     e.st, e.wr, e.addr, e.beat, e.last, e.data);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev       = cur;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = '0; in_is_store = '0; in_wr_rf = '0;
    in_rf_addr = '0; in_group_size = '0; in_data = '0;
    out_ready = 1'b0; clr_status = 1'b0;
    @(posedge clk); #1; @(posedge clk); #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Single capture, 4 beats back to back
    out_ready = 1'b1;
    set_port(0, 1'b0, 1'b1, 8'd8, 8'd4, 1, 99);
    step();
    chk("single_latency_valid", 32'(out_valid), 32'd1);
    chk("single_count1", 32'(count), 32'd1);
    step(); step(); step(); step();
    chk("single_count_after4", 32'(count), 32'd0);
    chk("single_valid_after4", 32'(out_valid), 32'd0);

    // Dual capture with toggling backpressure
    out_ready = 1'b0;
    set_port(0, 1'b1, 1'b0, 8'd20, 8'd3, 2, 99);
    set_port(1, 1'b0, 1'b1, 8'd40, 8'd2, 3, 99);
    step();
    chk("dual_count2", 32'(count), 32'd2);
    for (int i = 0; i < 16; i++) begin
      out_ready = ~out_ready;
      @(posedge clk); #1;
    end
    drain("dual", 20);

    // Overflow: fill to 7, then both ports with one slot left
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_port(0, 1'b0, 1'b1, 8'(10 + 2*i), 8'd1, 10 + 2*i, 99);
      set_port(1, 1'b0, 1'b1, 8'(11 + 2*i), 8'd1, 11 + 2*i, 99);
      step();
    end
    set_port(0, 1'b1, 1'b1, 8'd16, 8'd1, 16, 99);
    step();
    chk("ovf_count7", 32'(count), 32'd7);
    chk("ovf_flag_pre", 32'(overflow), 32'd0);
    set_port(0, 1'b0, 1'b0, 8'd17, 8'd1, 17, 99);
    set_port(1, 1'b0, 1'b0, 8'd18, 8'd1, 18, 0);
    step();
    chk("ovf_count8", 32'(count), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop1", 32'(drop_cnt), 32'd1);
    clr_status = 1'b1;
    step();
    chk("clr_flag", 32'(overflow), 32'd0);
    chk("clr_drop", 32'(drop_cnt), 32'd0);
    chk("clr_count_kept", 32'(count), 32'd8);
    clr_status = 1'b1;
    set_port(0, 1'b0, 1'b0, 8'd19, 8'd1, 19, 0);
    set_port(1, 1'b0, 1'b0, 8'd20, 8'd1, 20, 0);
    step();
    chk("clr_drop_prio_flag", 32'(overflow), 32'd1);
    chk("clr_drop_prio_cnt", 32'(drop_cnt), 32'd2);
    clr_status = 1'b1;
    step();
    // Full queue popping this cycle still refuses a same-cycle push
    out_ready = 1'b1;
    set_port(0, 1'b0, 1'b0, 8'd21, 8'd1, 21, 0);
    step();
    chk("pop_no_free_count", 32'(count), 32'd7);
    chk("pop_no_free_drop", 32'(drop_cnt), 32'd1);
    drain("ovf", 30);
    clr_status = 1'b1;
    step();

    // Group size clamp and address wrap
    set_port(0, 1'b0, 1'b1, 8'd3, 8'd0, 30, 99);
    step();
    drain("gs0", 10);
    set_port(1, 1'b1, 1'b0, 8'd100, 8'd20, 31, 99);
    step();
    chk("gs20_count", 32'(count), 32'd1);
    drain("gs20", 20);
    set_port(0, 1'b0, 1'b1, 8'd254, 8'd4, 32, 99);
    step();
    drain("wrap", 10);

    // Reset mid-stream after beats 0 and 1 of 4
    set_port(0, 1'b1, 1'b1, 8'd50, 8'd4, 40, 2);
    step();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_beat_before_rst", 32'(out_beat), 32'd2);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    set_port(1, 1'b0, 1'b1, 8'd77, 8'd2, 41, 0);
    step();
    reset = 1'b0;
    step();
    chk("rst_ignores_valid", 32'(count), 32'd0);
    set_port(0, 1'b0, 1'b1, 8'd60, 8'd2, 42, 99);
    step();
    chk("post_rst_beat0", 32'(out_beat), 32'd0);
    drain("post_rst", 10);

    // Drop counter saturation: 35000 cycles x 2 dropped ports
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_port(0, 1'b0, 1'b1, 8'(70 + 2*i), 8'd1, 70 + 2*i, 99);
      set_port(1, 1'b0, 1'b1, 8'(71 + 2*i), 8'd1, 71 + 2*i, 99);
      step();
    end
    chk("sat_full", 32'(count), 32'd8);
    set_port(0, 1'b0, 1'b0, 8'd0, 8'd1, 90, 0);
    set_port(1, 1'b0, 1'b0, 8'd0, 8'd1, 91, 0);
    for (int i = 1; i <= 35000; i++) begin
      @(posedge clk); #1;
      if (i == 32767) chk("sat_pre", 32'(drop_cnt), 32'h0000_FFFE);
    end
    in_valid = '0;
    chk("sat_hold", 32'(drop_cnt), 32'h0000_FFFF);
    chk("sat_count_kept", 32'(count), 32'd8);
    drain("sat", 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
